ppu_frame_writer: RTL

// Downstream consumer of the PPU core pixel stream (6-bit NES colour index plus pixel X/Y pointers).

---
 rtl/ppu_frame_writer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ppu_frame_writer.sv
// Packs four visible PPU pixels into 24-bit words, queues them, and streams them to a
// framebuffer write port. A new frame starts on FRAME_START; FRAME_DONE fires once the last word has left.
module ppu_frame_writer #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 14,
    parameter int FB_BASE    = 0,
    localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
    input  logic              PPU_SLOW_CLOCK,
    input  logic              RST,
    input  logic              PIX_VALID,
    input  logic [5:0]        PIX_DATA,
    input  logic [7:0]        PIX_X,
    input  logic [7:0]        PIX_Y,
    input  logic              FRAME_START,
    output logic [ADDR_W-1:0] FB_WR_ADDR,
    output logic [23:0]       FB_WR_DATA,
    output logic              FB_WR_VALID,
    input  logic              FB_WR_READY,
    output logic [LVL_W-1:0]  FIFO_LEVEL,
    output logic              OVERFLOW,
    output logic              FRAME_DONE
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    state_t              r_state;
    logic [5:0]          r_lane [4];
    logic [ADDR_W-1:0]   r_mem_addr [FIFO_DEPTH];
    logic [23:0]         r_mem_data [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_count;
    logic                r_overflow;
    logic                r_frame_done;

    logic                w_capture;
    logic                w_accept;
    logic                w_push;
    logic                w_full;
    logic                w_pop;
    logic                w_push_ok;
    logic                w_drop;
    logic                w_last;
    logic [5:0]          w_lane_next [4];
    logic [23:0]         w_word;
    logic [ADDR_W-1:0]   w_addr;

    // A pixel arriving with FRAME_START already belongs to the new frame.
    assign w_capture = FRAME_START || (r_state == S_CAPTURE);
    assign w_accept  = w_capture && PIX_VALID && (PIX_Y < 8'd240);
    assign w_push    = w_accept && (PIX_X[1:0] == 2'd3);
    assign w_full    = (r_count == LVL_W'(FIFO_DEPTH));
    assign w_pop     = (r_count != '0) && FB_WR_READY;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && !w_push_ok;
    assign w_last    = w_push && (PIX_X == 8'd255) && (PIX_Y == 8'd239);

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_lane_next[k] = FRAME_START ? 6'd0 : r_lane[k];
            if (w_accept && (PIX_X[1:0] == 2'(k)))
                w_lane_next[k] = PIX_DATA;
        end
    end

    assign w_word = {w_lane_next[3], w_lane_next[2], w_lane_next[1], w_lane_next[0]};
    assign w_addr = ADDR_W'(FB_BASE) + ADDR_W'({PIX_Y, 6'd0}) + ADDR_W'(PIX_X[7:2]);

    always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (FRAME_START) begin
                r_state <= w_last ? S_DRAIN : S_CAPTURE;
            end else begin
                case (r_state)
                    S_CAPTURE: if (w_last) r_state <= S_DRAIN;
                    S_DRAIN: begin
                        if (r_count == '0) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
            if (w_drop)
                r_overflow <= 1'b1;
            else if (FRAME_START)
                r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge PPU_SLOW_CLOCK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < 4; k++) r_lane[k] <= 6'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            for (int k = 0; k < 4; k++) r_lane[k] <= w_lane_next[k];
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the read port is masked whenever the FIFO is empty.
    always_ff @(posedge PPU_SLOW_CLOCK) begin
        if (w_push_ok) begin
            r_mem_addr[r_wr_ptr] <= w_addr;
            r_mem_data[r_wr_ptr] <= w_word;
        end
    end

    assign FB_WR_VALID = (r_count != '0);
    assign FB_WR_ADDR  = FB_WR_VALID ? r_mem_addr[r_rd_ptr] : '0;
    assign FB_WR_DATA  = FB_WR_VALID ? r_mem_data[r_rd_ptr] : '0;
    assign FIFO_LEVEL  = r_count;
    assign OVERFLOW    = r_overflow;
    assign FRAME_DONE  = r_frame_done;

endmodule
